// File: rtl/life_engine.sv
// Cell-serial Game of Life engine: one cell per clock into a shadow board, atomic commit.
// Define LIFE_WRAP_EN for a toroidal board; otherwise cells beyond the edge count as dead.
module life_engine #(
    parameter int BIT_WIDTH  = 3,
    parameter int BIT_HEIGHT = 3,
    parameter int FRAME_DIV  = 60,
    parameter logic [(2**(BIT_WIDTH+BIT_HEIGHT))-1:0] SEED = 64'h0000_0000_0007_0402
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic                          run,
    input  logic                          load,
    input  logic [BIT_WIDTH+BIT_HEIGHT-1:0] rd_addr,
    output logic                          rd_cell,
    output logic                          busy,
    output logic                          gen_done,
    output logic [15:0]                   generation
);

    localparam int N    = BIT_WIDTH + BIT_HEIGHT;
    localparam int SIZE = 2 ** N;
    localparam logic [7:0] FCNT_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t            state, next_state;
    logic [SIZE-1:0]   cur, nxt;
    logic [N-1:0]      idx;
    logic [7:0]        fcnt;
    logic              busy_d, gen_done_d;
    logic              trigger;

    logic [BIT_HEIGHT-1:0] row, nr;
    logic [BIT_WIDTH-1:0]  col, nc;
    logic                  in_board;
    logic [3:0]            count;
    logic                  new_cell;

    assign rd_cell = cur[rd_addr];
    assign trigger = frame_tick && run && (fcnt == FCNT_LAST);

    // State register plus registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gen_done <= 1'b0;
        end else begin
            state    <= next_state;
            busy     <= busy_d;
            gen_done <= gen_done_d;
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (trigger) next_state = SCAN;
                SCAN:    if (idx == N'(SIZE - 1)) next_state = COMMIT;
                COMMIT:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered, so they are decoded from the state being entered
    always_comb begin
        busy_d     = (next_state == SCAN) || (next_state == COMMIT);
        gen_done_d = (next_state == COMMIT);
    end

    // Neighbour count for the cell under evaluation
    always_comb begin
        row      = idx[N-1:BIT_WIDTH];
        col      = idx[BIT_WIDTH-1:0];
        nr       = '0;
        nc       = '0;
        in_board = 1'b0;
        count    = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (!(dr == 1 && dc == 1)) begin
                    nr = row + BIT_HEIGHT'(dr) - BIT_HEIGHT'(1);
                    nc = col + BIT_WIDTH'(dc) - BIT_WIDTH'(1);
`ifdef LIFE_WRAP_EN
                    in_board = 1'b1;
`else
                    in_board = !((dr == 0 && row == '0) || (dr == 2 && row == '1) ||
                                 (dc == 0 && col == '0) || (dc == 2 && col == '1));
`endif
                    count = count + {3'b000, cur[{nr, nc}] & in_board};
                end
            end
        end
        new_cell = (count == 4'd3) || (cur[idx] && count == 4'd2);
    end

    // Board, scan index, frame divider and generation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= SEED;
            nxt        <= '0;
            idx        <= '0;
            fcnt       <= '0;
            generation <= '0;
        end else if (load) begin
            cur        <= SEED;
            idx        <= '0;
            fcnt       <= '0;
            generation <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick && run) begin
                        if (fcnt == FCNT_LAST) begin
                            fcnt <= '0;
                            idx  <= '0;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                end
                SCAN: begin
                    nxt[idx] <= new_cell;
                    idx      <= idx + N'(1);
                end
                COMMIT: begin
                    cur        <= nxt;
                    generation <= generation + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
